// File: rtl/sort_floats_sequential.sv
// sort_floats_sequential: bubble sort of N floats through one shared
// less-or-equal comparator, one compare-and-swap per clock.

// Combinational IEEE-754 a <= b; err flags a NaN operand (res is then 0).
module f_less_or_equal #(
    parameter int FLEN = 64
) (
    input  logic [FLEN-1:0] a_i,
    input  logic [FLEN-1:0] b_i,
    output logic            res_o,
    output logic            err_o
);
    localparam int EW = (FLEN == 16) ? 5 : (FLEN == 32) ? 8 : 11;

    logic            a_s, b_s;
    logic [FLEN-2:0] a_m, b_m;
    logic            a_nan, b_nan;
    logic            a_zero, b_zero;

    assign a_s    = a_i[FLEN-1];
    assign b_s    = b_i[FLEN-1];
    assign a_m    = a_i[FLEN-2:0];
    assign b_m    = b_i[FLEN-2:0];
    assign a_nan  = (&a_i[FLEN-2 -: EW]) && (|a_i[FLEN-EW-2:0]);
    assign b_nan  = (&b_i[FLEN-2 -: EW]) && (|b_i[FLEN-EW-2:0]);
    assign a_zero = (a_m == '0);
    assign b_zero = (b_m == '0);
    assign err_o  = a_nan | b_nan;

    // Sign-magnitude ordering; -0 and +0 are treated as equal.
    always_comb begin
        res_o = 1'b0;
        if (!(a_nan || b_nan)) begin
            if (a_zero && b_zero) begin
                res_o = 1'b1;
            end else if (a_s != b_s) begin
                res_o = a_s;
            end else if (a_s) begin
                res_o = (a_m >= b_m);
            end else begin
                res_o = (a_m <= b_m);
            end
        end
    end
endmodule

module sort_floats_sequential #(
    parameter int N    = 4,
    parameter int FLEN = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [0:N-1][FLEN-1:0] up_data,
    output logic                   down_valid,
    input  logic                   down_ready,
    output logic [0:N-1][FLEN-1:0] down_data,
    output logic                   down_err
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_PASS = CW'(N - 2);

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

    state_t                 state_q;
    logic [0:N-1][FLEN-1:0] buf_q;
    logic [CW-1:0]          pass_q;
    logic [CW-1:0]          idx_q;
    logic                   err_q;
    logic                   up_ready_q;
    logic                   down_valid_q;

    logic [CW-1:0]          idx_d;
    logic [CW-1:0]          idx_last;
    logic [FLEN-1:0]        cmp_a;
    logic [FLEN-1:0]        cmp_b;
    logic                   cmp_res;
    logic                   cmp_err;

    // The inner loop shrinks by one element per completed pass.
    assign idx_d    = idx_q + 1'b1;
    assign idx_last = LAST_PASS - pass_q;
    assign cmp_a    = buf_q[idx_q];
    assign cmp_b    = buf_q[idx_d];

    f_less_or_equal #(
        .FLEN (FLEN)
    ) u_cmp (
        .a_i   (cmp_a),
        .b_i   (cmp_b),
        .res_o (cmp_res),
        .err_o (cmp_err)
    );

    // Sequencer: capture, one compare-and-swap per cycle, hold until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            pass_q       <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            up_ready_q   <= 1'b1;
            down_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (up_valid && up_ready_q) begin
                        buf_q      <= up_data;
                        pass_q     <= '0;
                        idx_q      <= '0;
                        err_q      <= 1'b0;
                        up_ready_q <= 1'b0;
                        state_q    <= SORT;
                    end
                end
                SORT: begin
                    // A NaN compare leaves the pair alone; equal never swaps.
                    if (!cmp_res && !cmp_err) begin
                        buf_q[idx_q] <= cmp_b;
                        buf_q[idx_d] <= cmp_a;
                    end
                    err_q <= err_q | cmp_err;
                    if (idx_q == idx_last) begin
                        idx_q <= '0;
                        if (pass_q == LAST_PASS) begin
                            down_valid_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            pass_q <= pass_q + 1'b1;
                        end
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    if (down_ready) begin
                        down_valid_q <= 1'b0;
                        up_ready_q   <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign up_ready   = up_ready_q;
    assign down_valid = down_valid_q;
    assign down_data  = buf_q;
    assign down_err   = err_q;
endmodule
